// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: byte-addressed little-endian instruction store with a
// program-load port and a registered fetch path. A fetch returns one word,
// or up to FETCH_WORDS consecutive words when bundle mode is requested and
// word0's top nibble equals BUNDLE_NIB.
//
// Handshake contract: a transfer happens on a rising edge where valid and
// ready are both high; a valid side never withdraws or changes its payload
// while waiting, and ready never depends on valid on the same interface.
// The output register FSM state is visible as rsp_valid (EMPTY=0, FULL=1).
module imem_fetch_unit #(
  parameter int          DEPTH_BYTES = 512,
  parameter int          FETCH_WORDS = 3,
  parameter logic [3:0]  BUNDLE_NIB  = 4'b1000,
  parameter int          CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  input  logic                     req_bundle,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [32*FETCH_WORDS-1:0] rsp_data,
  output logic [2:0]               rsp_nwords,
  output logic                     rsp_err,
  input  logic                     prog_we,
  input  logic [31:0]              prog_addr,
  input  logic [31:0]              prog_data,
  output logic [CNT_W-1:0]         fetch_cnt
);

  localparam int          AW      = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam logic [33:0] DEPTH34 = 34'(DEPTH_BYTES);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [7:0]               mem [DEPTH_BYTES];
  logic [0:0]               state;
  logic                     accept;
  logic [33:0]              prog_base;
  logic                     prog_in_rng;
  logic [FETCH_WORDS-1:0]   in_rng;
  logic [31:0]              word [FETCH_WORDS];
  logic                     req_err;
  logic                     bundle_ok;
  logic [32*FETCH_WORDS-1:0] nxt_data;
  logic [2:0]               nxt_nwords;

  // Program writes block fetch acceptance, so reads never collide with writes.
  assign req_ready = !prog_we && ((state == ST_EMPTY) || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == ST_FULL);

  // Address math is done 34 bits wide so that a+4k+3 overflowing 32 bits
  // simply compares as out of range instead of wrapping to low memory.
  assign prog_base   = {2'b00, prog_addr & 32'hFFFF_FFFC};
  assign prog_in_rng = (prog_base + 34'd3) < DEPTH34;

  // Per-slot range check and little-endian word assembly from the byte array.
  for (genvar k = 0; k < FETCH_WORDS; k++) begin : g_word
    logic [33:0] b;
    assign b         = {2'b00, req_addr} + 34'(4 * k);
    assign in_rng[k] = (b + 34'd3) < DEPTH34;
    assign word[k]   = in_rng[k] ? {mem[b[AW-1:0] + AW'(3)], mem[b[AW-1:0] + AW'(2)],
                                    mem[b[AW-1:0] + AW'(1)], mem[b[AW-1:0]]}
                                 : 32'd0;
  end

  assign req_err   = (req_addr[1:0] != 2'b00) || !in_rng[0];
  assign bundle_ok = req_bundle && (word[0][31:28] == BUNDLE_NIB);

  // Build the next response: word0 always, later slots only in bundle mode
  // and only while in range; everything past nwords stays zero.
  always_comb begin
    nxt_data   = '0;
    nxt_nwords = 3'd0;
    if (!req_err) begin
      for (int k = 0; k < FETCH_WORDS; k++) begin
        if (in_rng[k] && ((k == 0) || bundle_ok)) begin
          nxt_data[32*k +: 32] = word[k];
          nxt_nwords           = nxt_nwords + 3'd1;
        end
      end
    end
  end

  // Byte-array store; contents survive reset.
  always_ff @(posedge clk) begin
    if (prog_we && prog_in_rng) begin
      for (int i = 0; i < 4; i++) begin
        mem[prog_base[AW-1:0] + AW'(i)] <= prog_data[8*i +: 8];
      end
    end
  end

  // Output register FSM plus saturating accept counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      rsp_data   <= '0;
      rsp_nwords <= 3'd0;
      rsp_err    <= 1'b0;
      fetch_cnt  <= '0;
    end else if (accept) begin
      state      <= ST_FULL;
      rsp_data   <= nxt_data;
      rsp_nwords <= nxt_nwords;
      rsp_err    <= req_err;
      if (fetch_cnt != {CNT_W{1'b1}}) begin
        fetch_cnt <= fetch_cnt + CNT_W'(1);
      end
    end else if (rsp_ready) begin
      state <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Bench for imem_fetch_unit: directed vector table, hand-written multi-cycle
// sequences and a randomized run against a byte-array reference model.
module tb_imem_fetch_unit;

  localparam int DEPTH = 512;
  localparam int FW    = 3;
  localparam int DW    = 32 * FW;
  localparam int EW    = DW + 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_addr = '0;
  logic          req_bundle = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic [2:0]    rsp_nwords;
  logic          rsp_err;
  logic          prog_we = 1'b0;
  logic [31:0]   prog_addr = '0;
  logic [31:0]   prog_data = '0;
  logic [15:0]   fetch_cnt;

  logic          s_req_ready;
  logic          s_rsp_valid;
  logic [DW-1:0] s_rsp_data;
  logic [2:0]    s_rsp_nwords;
  logic          s_rsp_err;
  logic [2:0]    s_fetch_cnt;

  imem_fetch_unit #(.DEPTH_BYTES(DEPTH), .FETCH_WORDS(FW), .BUNDLE_NIB(4'b1000), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_bundle(req_bundle), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_nwords(rsp_nwords),
    .rsp_err(rsp_err), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .fetch_cnt(fetch_cnt)
  );

  // Narrow-counter copy sharing all inputs, used to reach counter saturation.
  imem_fetch_unit #(.DEPTH_BYTES(DEPTH), .FETCH_WORDS(FW), .BUNDLE_NIB(4'b1000), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_addr(req_addr), .req_bundle(req_bundle), .rsp_valid(s_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(s_rsp_data), .rsp_nwords(s_rsp_nwords),
    .rsp_err(s_rsp_err), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .fetch_cnt(s_fetch_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- model / scoreboard ----------------
  logic [7:0]    model_mem [DEPTH];
  logic [EW-1:0] exp_q [$];
  int            exp_cnt = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  typedef struct {
    logic [31:0]   addr;
    logic          bundle;
    logic          err;
    logic [2:0]    nw;
    logic [DW-1:0] data;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    logic [63:0] base;
    base = {32'd0, a} & ~64'd3;
    if (base + 64'd3 < 64'(DEPTH)) begin
      for (int i = 0; i < 4; i++) model_mem[int'(base) + i] = d[8*i +: 8];
    end
  endtask

  // Fetch semantics straight from the rules: error, else walk words upward,
  // stopping at the end of memory or when bundling is not permitted.
  function automatic logic [EW-1:0] model_fetch(input logic [31:0] a, input logic b);
    logic [63:0]   la;
    logic [63:0]   wa;
    logic [31:0]   w;
    logic [DW-1:0] d;
    int            n;
    d  = '0;
    n  = 0;
    la = {32'd0, a};
    if (a[1:0] != 2'b00 || la + 64'd3 >= 64'(DEPTH)) return {1'b1, 3'd0, {DW{1'b0}}};
    for (int k = 0; k < FW; k++) begin
      wa = la + 64'(4 * k);
      if (wa + 64'd3 >= 64'(DEPTH)) break;
      if (k > 0 && !(b && d[31:28] == 4'b1000)) break;
      w = {model_mem[int'(wa) + 3], model_mem[int'(wa) + 2], model_mem[int'(wa) + 1], model_mem[int'(wa)]};
      d[32*k +: 32] = w;
      n++;
    end
    return {1'b0, 3'(n), d};
  endfunction

  task automatic check_rsp(input string name, input logic [EW-1:0] e);
    check({name, ".valid"}, 128'(rsp_valid), 128'(1));
    check({name, ".err"}, 128'(rsp_err), 128'(e[EW-1]));
    check({name, ".nwords"}, 128'(rsp_nwords), 128'(e[EW-2 -: 3]));
    check({name, ".data"}, 128'(rsp_data), 128'(e[DW-1:0]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
    model_write(a, d);
  endtask

  // Issues one fetch with rsp_ready high; returns at the negedge after accept.
  task automatic do_fetch(input logic [31:0] a, input logic b);
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_bundle = b; rsp_ready = 1'b1;
    #1 check("fetch.req_ready", 128'(req_ready), 128'(1));
    @(negedge clk);
    req_valid = 1'b0;
    exp_cnt++;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [EW-1:0] snap;
    logic [31:0]   a;
    logic [31:0]   d;
    logic          exp_ready;
    logic          acc;
    logic          taken;
    logic [EW-1:0] push_v;

    vecs[0] = '{32'd0,   1'b1, 1'b0, 3'd3, {32'h0016E020, 32'h00C66020, 32'h8C230004}};
    vecs[1] = '{32'd4,   1'b1, 1'b0, 3'd1, {64'd0, 32'h00C66020}};
    vecs[2] = '{32'd0,   1'b0, 1'b0, 3'd1, {64'd0, 32'h8C230004}};
    vecs[3] = '{32'd2,   1'b1, 1'b1, 3'd0, {DW{1'b0}}};
    vecs[4] = '{32'd512, 1'b1, 1'b1, 3'd0, {DW{1'b0}}};
    vecs[5] = '{32'd508, 1'b1, 1'b0, 3'd1, {64'd0, 32'h8C000000}};
    vecs[6] = '{32'd504, 1'b1, 1'b0, 3'd2, {32'd0, 32'h8C000000, 32'h85555555}};
    vecs[7] = '{32'd500, 1'b1, 1'b0, 3'd3, {32'h8C000000, 32'h85555555, 32'h8AAAAAAA}};
    vecs[8] = '{32'hFFFFFFFC, 1'b1, 1'b1, 3'd0, {DW{1'b0}}};
    vecs[9] = '{32'd509, 1'b0, 1'b1, 3'd0, {DW{1'b0}}};

    // Reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset.rsp_valid", 128'(rsp_valid), 128'(0));
    check("reset.rsp_data", 128'(rsp_data), 128'(0));
    check("reset.rsp_nwords", 128'(rsp_nwords), 128'(0));
    check("reset.rsp_err", 128'(rsp_err), 128'(0));
    check("reset.fetch_cnt", 128'(fetch_cnt), 128'(0));
    check("reset.req_ready", 128'(req_ready), 128'(1));

    // Clear the whole store so the model and DUT start from known contents.
    for (int i = 0; i < DEPTH / 4; i++) do_write(32'(4 * i), 32'd0);

    do_write(32'd0,   32'h8C230004);
    do_write(32'd4,   32'h00C66020);
    do_write(32'd8,   32'h0016E020);
    do_write(32'd500, 32'h8AAAAAAA);
    do_write(32'd504, 32'h85555555);
    do_write(32'd510, 32'h8C000000);   // low bits ignored: lands at 508
    do_write(32'd512, 32'hDEADBEEF);   // dropped: past the end

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      do_fetch(vecs[i].addr, vecs[i].bundle);
      #1 check_rsp($sformatf("vec%0d", i), {vecs[i].err, vecs[i].nw, vecs[i].data});
    end
    check("vec.fetch_cnt", 128'(fetch_cnt), 128'(exp_cnt));

    // Backpressure: response held stable for 5 cycles, then a back-to-back load
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'd0; req_bundle = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    exp_cnt++;
    snap = model_fetch(32'd0, 1'b1);
    req_addr = 32'd4;
    #1;
    check("bp.req_ready_low", 128'(req_ready), 128'(0));
    check_rsp("bp.first", snap);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("bp.hold_ready", 128'(req_ready), 128'(0));
      check_rsp($sformatf("bp.hold%0d", i), snap);
      check("bp.hold_cnt", 128'(fetch_cnt), 128'(exp_cnt));
    end
    rsp_ready = 1'b1;
    #1 check("bp.release_ready", 128'(req_ready), 128'(1));
    @(negedge clk);
    exp_cnt++;
    req_valid = 1'b0;
    #1;
    check_rsp("bp.next", model_fetch(32'd4, 1'b1));
    check("bp.next_cnt", 128'(fetch_cnt), 128'(exp_cnt));
    @(negedge clk);
    #1 check("bp.drained", 128'(rsp_valid), 128'(0));

    // Program write and fetch in the same cycle: write wins, fetch next cycle
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 32'd8; prog_data = 32'h12345678;
    req_valid = 1'b1; req_addr = 32'd8; req_bundle = 1'b0; rsp_ready = 1'b1;
    #1 check("wr.req_ready_low", 128'(req_ready), 128'(0));
    @(negedge clk);
    model_write(32'd8, 32'h12345678);
    prog_we = 1'b0;
    #1;
    check("wr.no_accept", 128'(rsp_valid), 128'(0));
    check("wr.req_ready_high", 128'(req_ready), 128'(1));
    @(negedge clk);
    exp_cnt++;
    req_valid = 1'b0;
    #1 check_rsp("wr.new_word", {1'b0, 3'd1, 64'd0, 32'h12345678});

    // Asynchronous reset while a response is pending
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'd0; req_bundle = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    #1 check("arst.pre_valid", 128'(rsp_valid), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check("arst.rsp_valid", 128'(rsp_valid), 128'(0));
    check("arst.fetch_cnt", 128'(fetch_cnt), 128'(0));
    check("arst.rsp_data", 128'(rsp_data), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    exp_cnt = 0;
    exp_q.delete();

    // Randomized run against the reference model
    @(negedge clk);
    for (int cyc = 0; cyc < 600; cyc++) begin
      prog_we = ($urandom_range(0, 7) == 0);
      prog_addr = 32'($urandom_range(0, 131)) * 32'd4 + 32'($urandom_range(0, 3));
      d = $urandom;
      if ($urandom_range(0, 1) == 1) d[31:28] = 4'b1000;
      prog_data = d;
      req_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        6:       a = 32'($urandom_range(0, 520));
        7:       a = 32'hFFFF_FFFC - 32'($urandom_range(0, 3)) * 32'd4;
        8, 9:    a = 32'($urandom_range(122, 128)) * 32'd4;
        default: a = 32'($urandom_range(0, 129)) * 32'd4;
      endcase
      req_addr = a;
      req_bundle = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = !prog_we && (exp_q.size() == 0 || rsp_ready);
      check("rnd.req_ready", 128'(req_ready), 128'(exp_ready));
      check("rnd.rsp_valid", 128'(rsp_valid), 128'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("rnd.rsp", 128'({rsp_err, rsp_nwords, rsp_data}), 128'(exp_q[0]));
      end
      check("rnd.fetch_cnt", 128'(fetch_cnt), 128'(exp_cnt));
      check("rnd.sat_cnt", 128'(s_fetch_cnt), 128'((exp_cnt > 7) ? 7 : exp_cnt));
      acc   = req_valid && exp_ready;
      taken = (exp_q.size() != 0) && rsp_ready;
      push_v = model_fetch(a, req_bundle);
      @(posedge clk);
      if (taken) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(push_v);
        exp_cnt++;
      end
      if (prog_we) model_write(prog_addr, prog_data);
      @(negedge clk);
    end
    req_valid = 1'b0;
    prog_we = 1'b0;

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
